// File: rtl/button_debounce.sv
// Button synchroniser and debouncer producing a clean one-cycle press pulse,
// optional auto-repeat while held, the debounced level and a press counter.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 0,
    parameter int unsigned REPEAT_PERIOD   = 8,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    input  logic       enable,
    output logic       press_pulse,
    output logic       btn_level,
    output logic [7:0] press_count,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    localparam int unsigned RD_M1 =
        (REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_M1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam bit REPEAT_EN = (REPEAT_DELAY != 0);

    logic             ff1_q, ff2_q;
    logic             button_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_rep_q, first_rep_d;
    logic             pulse_q, pulse_d;
    logic [7:0]       count_q, count_d;
    logic             fire;

    assign button_s = ff2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff1_q       <= 1'b0;
            ff2_q       <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            first_rep_q <= 1'b1;
            pulse_q     <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            ff1_q       <= button;
            ff2_q       <= ff1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            first_rep_q <= first_rep_d;
            pulse_q     <= pulse_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        first_rep_d = first_rep_q;
        fire        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (button_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!button_s) begin
                    state_d = IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d     = HELD;
                    cnt_d       = '0;
                    first_rep_d = 1'b1;
                    fire        = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!button_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (REPEAT_EN) begin
                    // First repeat waits the longer delay, later ones the period
                    if (cnt_q == (first_rep_q ? RD_LAST : RP_LAST)) begin
                        fire        = 1'b1;
                        cnt_d       = '0;
                        first_rep_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RELEASE_WAIT: begin
                if (button_s) begin
                    state_d     = HELD;
                    cnt_d       = '0;
                    first_rep_d = 1'b1;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        pulse_d = fire & enable;
        count_d = count_q + {7'd0, pulse_d};
    end

    always_comb begin
        btn_level   = (state_q == HELD) || (state_q == RELEASE_WAIT);
        state_dbg   = state_q;
        press_pulse = pulse_q;
        press_count = count_q;
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: one plain instance and one with
// auto-repeat enabled, checked with immediate assertions.
module tb_button_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_a = 1'b0, en_a = 1'b1;
    logic       btn_r = 1'b0, en_r = 1'b1;
    logic       pls_a, lvl_a, pls_r, lvl_r;
    logic [7:0] cnt_a, cnt_r;
    logic [1:0] st_a, st_r;

    int checks = 0;
    int errors = 0;
    int npa = 0;
    int npr = 0;
    int base;

    always #5 clk = ~clk;

    button_debounce #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0),
        .REPEAT_PERIOD(8), .CNT_W(20)
    ) dut_a (
        .clk(clk), .rst(rst), .button(btn_a), .enable(en_a),
        .press_pulse(pls_a), .btn_level(lvl_a),
        .press_count(cnt_a), .state_dbg(st_a)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10),
        .REPEAT_PERIOD(5), .CNT_W(20)
    ) dut_r (
        .clk(clk), .rst(rst), .button(btn_r), .enable(en_r),
        .press_pulse(pls_r), .btn_level(lvl_r),
        .press_count(cnt_r), .state_dbg(st_r)
    );

    always @(negedge clk) begin
        if (pls_a === 1'b1) npa++;
        if (pls_r === 1'b1) npr++;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    initial begin
        // Reset values
        tick(2);
        chk("rst_pulse", {31'd0, pls_a}, 0);
        chk("rst_level", {31'd0, lvl_a}, 0);
        chk("rst_count", {24'd0, cnt_a}, 0);
        chk("rst_state", {30'd0, st_a}, 0);
        chk("rst_count_r", {24'd0, cnt_r}, 0);
        rst = 1'b1;
        tick(1);

        // Reset during PRESS_WAIT
        btn_a = 1'b1;
        tick(3);
        chk("pw_state", {30'd0, st_a}, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_state", {30'd0, st_a}, 0);
        tick(2);
        chk("mid_rst_pulse", {31'd0, pls_a}, 0);
        chk("mid_rst_level", {31'd0, lvl_a}, 0);
        chk("mid_rst_count", {24'd0, cnt_a}, 0);
        rst = 1'b1;
        tick(6);
        chk("rr_pulse_early", {31'd0, pls_a}, 0);
        tick(1);
        chk("rr_pulse", {31'd0, pls_a}, 1);
        chk("rr_count", {24'd0, cnt_a}, 1);

        // Clean press
        btn_a = 1'b0;
        do_reset();
        tick(2);
        base = npa;
        btn_a = 1'b1;
        tick(6);
        chk("cp_pulse_early", {31'd0, pls_a}, 0);
        chk("cp_level_early", {31'd0, lvl_a}, 0);
        tick(1);
        chk("cp_pulse", {31'd0, pls_a}, 1);
        chk("cp_level", {31'd0, lvl_a}, 1);
        chk("cp_state", {30'd0, st_a}, 2);
        tick(1);
        chk("cp_pulse_width", {31'd0, pls_a}, 0);
        tick(12);
        chk("cp_npulse", npa - base, 1);
        chk("cp_count", {24'd0, cnt_a}, 1);

        // Release bounce from HELD
        btn_a = 1'b0;
        tick(2);
        btn_a = 1'b1;
        tick(1);
        btn_a = 1'b0;
        tick(6);
        chk("rb_level_hold", {31'd0, lvl_a}, 1);
        tick(1);
        chk("rb_level_fall", {31'd0, lvl_a}, 0);
        chk("rb_state", {30'd0, st_a}, 0);
        tick(4);
        chk("rb_npulse", npa - base, 1);

        // Bounce rejection
        do_reset();
        tick(2);
        base = npa;
        btn_a = 1'b1; tick(1);
        btn_a = 1'b1; tick(1);
        btn_a = 1'b0; tick(1);
        btn_a = 1'b1; tick(1);
        btn_a = 1'b0; tick(1);
        btn_a = 1'b1; tick(1);
        tick(5);
        chk("br_npulse_early", npa - base, 0);
        chk("br_level_early", {31'd0, lvl_a}, 0);
        tick(1);
        chk("br_pulse", {31'd0, pls_a}, 1);
        tick(6);
        chk("br_npulse", npa - base, 1);
        chk("br_count", {24'd0, cnt_a}, 1);
        btn_a = 1'b0;
        tick(8);

        // Auto-repeat: pulses at e0+6, then every 10, 5, 5, ... cycles
        do_reset();
        tick(2);
        btn_r = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            int e;
            logic exp_p;
            tick(1);
            e = k - 1;
            exp_p = (e == 6) || (e >= 16 && ((e - 16) % 5) == 0);
            chk("ar_pulse", {31'd0, pls_r}, {31'd0, exp_p});
        end
        chk("ar_count", {24'd0, cnt_r}, 6);
        chk("ar_npulse", npr, 6);
        btn_r = 1'b0;
        tick(8);
        chk("ar_level_off", {31'd0, lvl_r}, 0);

        // Enable gating
        do_reset();
        tick(2);
        base = npa;
        en_a = 1'b0;
        btn_a = 1'b1;
        tick(10);
        chk("en_level", {31'd0, lvl_a}, 1);
        chk("en_count", {24'd0, cnt_a}, 0);
        btn_a = 1'b0;
        tick(10);
        chk("en_level_off", {31'd0, lvl_a}, 0);
        chk("en_npulse", npa - base, 0);

        // Counter wrap after 256 presses
        en_a = 1'b1;
        for (int p = 0; p < 256; p++) begin
            btn_a = 1'b1;
            tick(8);
            btn_a = 1'b0;
            tick(8);
            if (p == 254) chk("wrap_255", {24'd0, cnt_a}, 255);
        end
        chk("wrap_0", {24'd0, cnt_a}, 0);
        chk("wrap_npulse", npa - base, 256);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Front-end conditioning stage directly upstream of valid_in in the button -> valid_in -> counter -> shift_regg -> memory_driver_off chain.
- Synchronises the raw mechanical button input and debounces it with an FSM and counter.
- Emits a clean one-cycle press_pulse per debounced press, plus optional auto-repeat pulses while the button is held.
- Also provides the debounced level and a running press count for debug and LEDs.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable samples required to accept a press or a release; must be >= 2.
- REPEAT_DELAY, 0, cycles in HELD before the first auto-repeat pulse; 0 disables auto-repeat.
- REPEAT_PERIOD, 8, cycles between successive auto-repeat pulses; must be >= 1.
- CNT_W, 20, width of the internal debounce/repeat counter; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk  in  1  single system clock; all flops are rising-edge.
- rst  in  1  asynchronous, active-low reset.
- button  in  1  raw asynchronous button level; 1 = pressed.
- enable  in  1  1 = pulses and count updates allowed; 0 = suppressed while the FSM keeps tracking.
- press_pulse  out  1  one-cycle pulse per accepted press or auto-repeat; feeds valid_in.
- btn_level  out  1  debounced button level.
- press_count  out  8  number of emitted press_pulse events, wrapping.
- state_dbg  out  2  current FSM state encoding.

Behaviour:
- Reset (rst=0, async):
  - sync flops ff1 and ff2 = 0, state = IDLE, cnt = 0.
  - press_pulse = 0, btn_level = 0, press_count = 0, state_dbg = 0.
  - Asserting reset mid-operation aborts immediately. No pulse is emitted on reset release.
- Synchroniser: two-flop chain, ff1 <= button, ff2 <= ff1. button_s = ff2. The FSM sees only button_s.
- States: IDLE=0, PRESS_WAIT=1, HELD=2, RELEASE_WAIT=3.
- IDLE:
  - btn_level = 0.
  - If button_s = 1, go to PRESS_WAIT with cnt <= 0.
- PRESS_WAIT:
  - If button_s = 0, return to IDLE with no pulse (bounce rejected).
  - Else if cnt == DEBOUNCE_CYCLES-1, go to HELD: btn_level <= 1, press_pulse <= enable, press_count += enable, cnt <= 0.
  - Else cnt++.
- HELD:
  - If button_s = 0, go to RELEASE_WAIT with cnt <= 0.
  - Else if REPEAT_DELAY != 0, count in HELD:
    - When cnt == REPEAT_DELAY-1 for the first repeat, emit a repeat pulse (gated by enable) and reload cnt <= 0.
    - For each later repeat, emit a pulse when cnt == REPEAT_PERIOD-1, then reload.
    - A first_rep flag selects which threshold applies.
- RELEASE_WAIT:
  - If button_s = 1, return to HELD with no new pulse. The repeat counter restarts from the REPEAT_DELAY phase.
  - Else if cnt == DEBOUNCE_CYCLES-1, go to IDLE with btn_level <= 0.
  - Else cnt++.
- Latency: with button stable high, let e0 be the first edge at which ff1 samples 1. press_pulse is high in the cycle following edge e0+DEBOUNCE_CYCLES+2. btn_level rises on the same edge.
- Release latency: the same DEBOUNCE_CYCLES+2 edges, measured to btn_level falling.
- Output timing:
  - press_pulse is registered and always exactly 1 cycle wide; it is never asserted on two consecutive cycles.
  - Exception: REPEAT_PERIOD=1 produces back-to-back pulses, and that is legal.
- Enable gating:
  - enable=0 blocks press_pulse and press_count increments; FSM and btn_level are unaffected.
  - enable is sampled on the edge where the pulse would be registered.
- press_count wraps 255 -> 0 with no flag.
- A glitch shorter than DEBOUNCE_CYCLES of synchronised samples never produces a pulse and never changes btn_level.

Test Plan:
- Reset during PRESS_WAIT: DEBOUNCE_CYCLES=4, button high for 3 cycles, then rst=0 for 2 cycles while button stays high -> all outputs 0 during reset. After release, the first pulse occurs 6 edges after ff1 first resamples 1.
- Clean press: DEBOUNCE_CYCLES=4, rst deasserted, enable=1, button held high 20 cycles -> exactly one press_pulse, 6 edges after e0. btn_level=1 from the same edge; press_count=1.
- Bounce rejection: DEBOUNCE_CYCLES=4, button toggles 1,1,0,1,0,1 per cycle, then high -> no pulse during toggling; a single pulse once 4 stable synchronised highs are seen; press_count=1.
- Release bounce: from HELD, button low 2 cycles, high 1 cycle, then low 10 cycles -> no extra pulse, btn_level stays 1 through the bounce, then falls 6 edges after the final low is sampled into ff1.
- Auto-repeat: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, button held 40 cycles -> initial pulse, then repeats 10, 15, 20, ... cycles after it. press_count matches the pulse total.
- Enable and wrap: enable=0 for one press -> btn_level toggles, but no pulse and no count change. Then 256 pulses with enable=1 -> press_count returns to 0.
